// File: rtl/msg_ctrl_pkg.sv
// Shared types and constants for the message sequencer.
package msg_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam int MSG_W                   = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_AUTO_FRAMES     = 120;

    // Wrapping increment of the message index over num_msgs entries.
    function automatic logic [MSG_W-1:0] next_msg(input logic [MSG_W-1:0] idx,
                                                  input int num_msgs);
        logic [MSG_W-1:0] last;
        last = MSG_W'(num_msgs - 1);
        if (idx >= last) begin
            next_msg = '0;
        end else begin
            next_msg = idx + 1'b1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level counter, rising-edge pulse.
module btn_debounce
    import msg_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Accept the synced level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, its delayed copy and the registered press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/msg_sequencer.sv
// Message index controller: debounced next/auto buttons, frame-aligned advances.
//
// state   | meaning
// IDLE    | no manual request outstanding
// PENDING | next pressed, advance at the coming frame_start
module msg_sequencer
    import msg_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_MSGS        = 2,
    parameter int AUTO_FRAMES     = DEFAULT_AUTO_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_next,
    input  logic             btn_auto,
    input  logic             frame_start,
    output logic [MSG_W-1:0] msg_idx,
    output logic             msg_changed,
    output logic             auto_mode
);

    localparam int FCW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(AUTO_FRAMES - 1);

    logic next_press, auto_press;
    logic next_level, auto_level;

    state_e           state_q, state_d;
    logic [MSG_W-1:0] idx_q, idx_d;
    logic             changed_q, changed_d;
    logic             auto_q, auto_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic             auto_due, advance;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_next),
        .level   (next_level),
        .press   (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_auto),
        .level   (auto_level),
        .press   (auto_press)
    );

    // Debounced levels are not needed here; only the press pulses are.
    logic unused_levels;
    assign unused_levels = &{1'b0, next_level, auto_level};

    assign auto_due = auto_q && (fcnt_q == FRAME_LAST);
    assign advance  = frame_start && ((state_q == PENDING) || auto_due);

    // Next-state logic for the request FSM, index, auto mode and frame counter.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        changed_d = 1'b0;
        auto_d    = auto_q;
        fcnt_d    = fcnt_q;

        if (advance) begin
            idx_d     = next_msg(idx_q, NUM_MSGS);
            changed_d = 1'b1;
            fcnt_d    = '0;
            // A press arriving on the advancing edge from IDLE still opens a new request.
            state_d   = (state_q == IDLE && next_press) ? PENDING : IDLE;
        end else begin
            if (next_press) begin
                state_d = PENDING;
            end
            if (auto_q && frame_start) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        if (auto_press) begin
            auto_d = ~auto_q;
            fcnt_d = '0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            changed_q <= 1'b0;
            auto_q    <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            changed_q <= changed_d;
            auto_q    <= auto_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign msg_idx     = idx_q;
    assign msg_changed = changed_q;
    assign auto_mode   = auto_q;

endmodule

// File: doc/msg_sequencer.md
Name: msg_sequencer

Overview:
Controller that drives the 2-bit message index of the on-screen text generator. It debounces two push buttons: "next" advances the message, "auto" toggles timed auto-advance. Every message change is deferred to a frame-start pulse from the VGA timing block, so the text never changes mid-frame. It sits between the board buttons / VGA sync generator and the text ROM's msg_idx input.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button level is accepted (10 ms at 25 MHz).
NUM_MSGS, 2, number of valid messages; legal range 1..4.
AUTO_FRAMES, 120, frame-start pulses between auto-advances (2 s at 60 Hz); must be >= 1.

Ports:
clk  in  1  pixel clock; the only clock.
rst  in  1  asynchronous, active-high reset.
btn_next  in  1  raw, asynchronous "next message" button; active-high.
btn_auto  in  1  raw, asynchronous "toggle auto mode" button; active-high.
frame_start  in  1  one-cycle pulse at start of vertical blank; synchronous to clk.
msg_idx  out  2  current message number to the text ROM.
msg_changed  out  1  one-cycle pulse, high in the same cycle msg_idx first shows a new value.
auto_mode  out  1  1 = timed auto-advance enabled.

Behaviour:
- Reset (async assert, sync-effect deassert): msg_idx=0, msg_changed=0, auto_mode=0, state=IDLE. Frame counter, pending flag, debounce counters and sync flops are cleared; debounced levels = 0.
- Button conditioning, per button: 2-FF synchroniser, then stable counter. The debounced level takes the synced value once it has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles. Any cycle where they match clears the counter. A rising edge of the debounced level gives a one-cycle press pulse. Latency from a clean press to the pulse is DEBOUNCE_CYCLES+3 cycles. A release emits no pulse.
- auto press: toggles auto_mode on the next edge. The frame counter clears on every toggle.
- FSM state IDLE: a next press -> PENDING.
- FSM state PENDING: waits for frame_start. Further next presses while PENDING are absorbed; the request does not queue a second advance.
- Advance, on the clk edge where frame_start=1 and either state=PENDING or an auto expiry is due:
  - msg_idx <= (msg_idx==NUM_MSGS-1) ? 0 : msg_idx+1.
  - msg_changed <= 1 for exactly that one cycle.
  - state <= IDLE; frame counter <= 0.
- Auto expiry: when auto_mode=1, the frame counter increments on each frame_start. Expiry is due when the counter equals AUTO_FRAMES-1 at a frame_start. The counter width is sized for AUTO_FRAMES-1.
- Simultaneous manual request and auto expiry on the same frame_start -> exactly one advance.
- A manual advance also restarts the auto interval.
- NUM_MSGS=1: an advance keeps msg_idx=0 but still pulses msg_changed.
- frame_start and a next press in the same cycle: the press enters PENDING and is not applied until the next frame_start (the request must already be pending).
- auto toggled off while a manual request is PENDING: the request is still applied at the next frame_start.
- msg_idx never exceeds NUM_MSGS-1.
- rst asserted mid-debounce or mid-PENDING: everything returns to reset values immediately. A button held through reset release produces a press pulse after re-debouncing.

Decomposition:
- Package msg_ctrl_pkg holds:
  - the state enum {IDLE, PENDING};
  - MSG_W=2 for the message index width;
  - the default DEBOUNCE_CYCLES and AUTO_FRAMES constants.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, press): synchroniser, stable counter and edge pulse. Instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_MSGS=2):
- Reset, then btn_next held 20 cycles with no frame_start -> msg_idx stays 0, no msg_changed; pulse frame_start -> next edge msg_idx=1, msg_changed high 1 cycle.
- btn_next glitches high for 3 cycles (< DEBOUNCE_CYCLES), then frame_start -> msg_idx unchanged, msg_changed never asserted.
- Two clean presses before one frame_start, starting from msg_idx=1 -> single advance to 0 (wrap), one msg_changed pulse.
- Press auto, then 7 frame_start pulses with no next press -> auto_mode=1; advances on the 3rd and 6th pulses only (msg_idx 0->1->0).
- Auto mode on, counter at 2 and a manual request pending at the same frame_start -> exactly one advance; the following advance comes 3 frame_starts later.
- rst asserted while PENDING with msg_idx=1 -> immediately msg_idx=0, auto_mode=0; the next frame_start after release causes no advance.
